sfa_cmd_issuer: RTL and testbench
=================================

Name: sfa_cmd_issuer

Overview:
- Host-side initiator for the SFA control command stream. It is the counterpart that drives the controller's 32-bit command input and consumes its 32-bit return word.
- Accepts one job descriptor per handshake and expands it into the fixed instruction sequence: configure, VSET, VSTART, VDONE.
- Waits for the return word, checks it, and reports a status word upstream, for example to a testbench driver or a microcontroller bridge.

Parameters:
- RET_TIMEOUT, default 1024: cycles to wait for the return word in WAIT_RET. 0 disables the timeout.
- RET_EXPECT, default 32'd10: return value counted as success.

Ports:
- ACLK  in  1  clock; all logic on the rising edge.
- ARESET  in  1  synchronous reset, active-high.
- sJOB_tvalid  in  1  job descriptor valid.
- sJOB_tready  out  1  issuer idle and able to accept a job.
- sJOB_tdata  in  128  packed job descriptor (layout under Behaviour).
- mCMD_tvalid  out  1  instruction word valid.
- mCMD_tready  in  1  controller accepts the instruction.
- mCMD_tdata  out  32  instruction word: [31:16] opcode, [15:0] operand.
- sRet_tvalid  in  1  return word valid.
- sRet_tready  out  1  issuer ready for the return word.
- sRet_tdata  in  32  return word.
- mSTAT_tvalid  out  1  status valid.
- mSTAT_tready  in  1  status consumer ready.
- mSTAT_code  out  2  status: 00 OK, 01 BAD_RET, 10 TIMEOUT.
- mSTAT_ret  out  32  captured return word; 0 on TIMEOUT.

Behaviour:
- Descriptor layout:
  - [15:0] PR_SIZE; [31:16] BC1_INDEX; [47:32] BC1_SIZE; [63:48] BC1_STRIDE
  - [79:64] BC2_INDEX; [95:80] BC2_SIZE; [111:96] BC2_STRIDE
  - [112] BC1_MODE; [113] BC2_MODE; [115:114] IN1; [117:116] IN2; [118] MUX; [120:119] OUT
  - [127:121] ignored
- States: IDLE, ISSUE, WAIT_RET, REPORT. Reset enters IDLE.
- Reset values: all valids and readies low, except sJOB_tready, which is 1 once in IDLE. mCMD_tdata, mSTAT_code and mSTAT_ret are 0. Word index is 0. Timeout counter is 0.
- sJOB_tready is asserted exactly when the state is IDLE.
- IDLE: on sJOB_tvalid, register the descriptor, clear the word index, and go to ISSUE.
- ISSUE: 12 words are issued in index order:
  - 0: {16'h10, PR_SIZE}
  - 1: {16'h11, BC1_INDEX}
  - 2: {16'h12, BC1_SIZE}
  - 3: {16'h13, BC1_STRIDE}
  - 4: {16'h14, 15'b0, BC1_MODE}
  - 5: {16'h21, BC2_INDEX}
  - 6: {16'h22, BC2_SIZE}
  - 7: {16'h23, BC2_STRIDE}
  - 8: {16'h24, 15'b0, BC2_MODE}
  - 9: {16'h1, 2'b0, IN1, IN2, 7'b0, MUX, OUT}
  - 10: {16'h3, 16'h0}
  - 11: {16'h8, 16'h0}
- ISSUE handshake:
  - mCMD_tvalid is high in ISSUE.
  - mCMD_tdata is stable while tvalid is high and tready is low.
  - The index advances only on tvalid && tready.
  - Acceptance of word 11 moves to WAIT_RET on the same edge, with the timeout counter cleared.
  - Back-to-back acceptance gives one word per cycle.
- WAIT_RET:
  - sRet_tready=1.
  - On sRet_tvalid: capture the data; code = 00 if the data equals RET_EXPECT, else 01; go to REPORT.
  - Otherwise the counter increments. When RET_TIMEOUT != 0 and the counter reaches RET_TIMEOUT-1 with no valid, code = 10, ret = 0, go to REPORT.
  - If a valid word arrives in the same cycle as expiry, the valid word wins.
- REPORT: mSTAT_tvalid=1 with stable fields; on mSTAT_tready go to IDLE. The status fields hold their value until the next capture.
- Minimum job latency:
  - Descriptor accept to first mCMD_tvalid: 1 cycle.
  - Last command accepted to sRet_tready: 1 cycle.
  - Return captured to mSTAT_tvalid: 1 cycle.
- ARESET in any state aborts the job at that edge: all outputs return to reset values and partially issued sequences are not resumed.
- sJOB_tvalid, sRet_tvalid and mSTAT_tready outside their accepting states are ignored.

Optional Feature:
- SFA_CMD_SKIP_UNCHANGED_EN defined:
  - Shadow registers plus a valid bit per config word (indices 0-8) hold the last operand accepted by the controller.
  - In ISSUE, a config word whose shadow is valid and equal to the new operand is skipped. It takes one cycle with mCMD_tvalid low and the index advanced.
  - Words 9-11 are never skipped.
  - Shadows are invalidated by ARESET and also on a TIMEOUT status.
- Undefined: all 12 words are always issued; no shadow logic exists.

Decomposition:
- Package sfa_cmd_pkg holds:
  - the opcode constants (0x1, 0x3, 0x8, 0x10-0x14, 0x21-0x24)
  - the status codes
  - the descriptor field offsets
  - the state enum
- It is shared with the controller for opcode consistency.
- One sub-module, sfa_cmd_word_rom: combinational index+descriptor -> 32-bit word. It keeps the sequencer FSM separate from the encoding.

Test Plan:
- Job with PR_SIZE=0x40, BC1 index/size/stride/mode = 0x0000/0x40/0x1/1, BC2 = 0x100/0x40/0x1/0, IN1=1, IN2=2, MUX=1, OUT=3, tready always 1 -> 12 words in 12 consecutive cycles:
  - 0x00100040 … 0x00011807, 0x00030000, 0x00080000
  - then ret 10 -> code 00, ret 0x0A.
- mCMD_tready toggling randomly -> identical word order, each word stable until accepted, no duplicates or drops.
- Return 0x0B -> code 01, ret 0x0B. With RET_TIMEOUT=16 and no return -> code 10 exactly 16 cycles after entering WAIT_RET.
- ARESET asserted after word 5 is accepted -> next cycle IDLE, sJOB_tready=1. A new job restarts at word 0.
- mSTAT_tready held low 20 cycles -> status stable, sJOB_tready stays low until accepted.
- With SFA_CMD_SKIP_UNCHANGED_EN, the same job issued twice -> the second sequence issues only VSET, VSTART, VDONE. Changing BC2_SIZE issues 0x00220080 plus those three.

Source files
------------

// File: rtl/sfa_cmd_pkg.sv
// ---------------------------------------------------------------------------
// sfa_cmd_pkg
// Shared definitions for the SFA control command stream. The issuer and the
// controller both import this package so that opcodes stay consistent.
//   - opcode constants for every instruction word
//   - status codes reported by the issuer
//   - bit offsets of the fields in the 128-bit job descriptor
//   - issuer state enum and word-sequence constants
// ---------------------------------------------------------------------------
package sfa_cmd_pkg;

    // Opcodes (upper half of each 32-bit instruction word)
    localparam logic [15:0] OP_VSET       = 16'h0001;
    localparam logic [15:0] OP_VSTART     = 16'h0003;
    localparam logic [15:0] OP_VDONE      = 16'h0008;
    localparam logic [15:0] OP_PR_SIZE    = 16'h0010;
    localparam logic [15:0] OP_BC1_INDEX  = 16'h0011;
    localparam logic [15:0] OP_BC1_SIZE   = 16'h0012;
    localparam logic [15:0] OP_BC1_STRIDE = 16'h0013;
    localparam logic [15:0] OP_BC1_MODE   = 16'h0014;
    localparam logic [15:0] OP_BC2_INDEX  = 16'h0021;
    localparam logic [15:0] OP_BC2_SIZE   = 16'h0022;
    localparam logic [15:0] OP_BC2_STRIDE = 16'h0023;
    localparam logic [15:0] OP_BC2_MODE   = 16'h0024;

    // Status codes
    localparam logic [1:0] STAT_OK      = 2'b00;
    localparam logic [1:0] STAT_BAD_RET = 2'b01;
    localparam logic [1:0] STAT_TIMEOUT = 2'b10;

    // Descriptor field offsets (LSB of each field)
    localparam int unsigned DESC_PR_SIZE_LSB    = 0;
    localparam int unsigned DESC_BC1_INDEX_LSB  = 16;
    localparam int unsigned DESC_BC1_SIZE_LSB   = 32;
    localparam int unsigned DESC_BC1_STRIDE_LSB = 48;
    localparam int unsigned DESC_BC2_INDEX_LSB  = 64;
    localparam int unsigned DESC_BC2_SIZE_LSB   = 80;
    localparam int unsigned DESC_BC2_STRIDE_LSB = 96;
    localparam int unsigned DESC_BC1_MODE_BIT   = 112;
    localparam int unsigned DESC_BC2_MODE_BIT   = 113;
    localparam int unsigned DESC_IN1_LSB        = 114;
    localparam int unsigned DESC_IN2_LSB        = 116;
    localparam int unsigned DESC_MUX_BIT        = 118;
    localparam int unsigned DESC_OUT_LSB        = 119;

    // Bits [127:121] carry nothing, so only the low 121 bits are stored.
    localparam int unsigned DESC_USED_WIDTH = 121;

    // Word sequence: indices 0-8 configure, 9 VSET, 10 VSTART, 11 VDONE
    localparam int unsigned NUM_CONFIG_WORDS = 9;
    localparam logic [3:0]  LAST_WORD_INDEX  = 4'd11;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RET,
        REPORT
    } issuer_state_t;

    function automatic logic is_config_word(input logic [3:0] index);
        return index < 4'(NUM_CONFIG_WORDS);
    endfunction

endpackage

// File: rtl/sfa_cmd_word_rom.sv
// ---------------------------------------------------------------------------
// sfa_cmd_word_rom
// Purely combinational encoder: maps a word index (0-11) and the stored job
// descriptor to the 32-bit instruction word {opcode, operand}. Keeps the
// sequencer FSM free of encoding details.
// Ports:
//   index  in   4    word position in the sequence
//   desc   in   121  descriptor (ignored top bits already stripped)
//   word   out  32   instruction word; 0 for indices above 11
// ---------------------------------------------------------------------------
module sfa_cmd_word_rom
    import sfa_cmd_pkg::*;
(
    input  logic [3:0]                 index,
    input  logic [DESC_USED_WIDTH-1:0] desc,
    output logic [31:0]                word
);

    always_comb begin
        word = 32'h0;
        case (index)
            4'd0:  word = {OP_PR_SIZE,    desc[DESC_PR_SIZE_LSB    +: 16]};
            4'd1:  word = {OP_BC1_INDEX,  desc[DESC_BC1_INDEX_LSB  +: 16]};
            4'd2:  word = {OP_BC1_SIZE,   desc[DESC_BC1_SIZE_LSB   +: 16]};
            4'd3:  word = {OP_BC1_STRIDE, desc[DESC_BC1_STRIDE_LSB +: 16]};
            4'd4:  word = {OP_BC1_MODE,   15'b0, desc[DESC_BC1_MODE_BIT]};
            4'd5:  word = {OP_BC2_INDEX,  desc[DESC_BC2_INDEX_LSB  +: 16]};
            4'd6:  word = {OP_BC2_SIZE,   desc[DESC_BC2_SIZE_LSB   +: 16]};
            4'd7:  word = {OP_BC2_STRIDE, desc[DESC_BC2_STRIDE_LSB +: 16]};
            4'd8:  word = {OP_BC2_MODE,   15'b0, desc[DESC_BC2_MODE_BIT]};
            // VSET operand packs the routing fields: IN1 at [13:12],
            // IN2 at [11:10], MUX at [2], OUT at [1:0].
            4'd9:  word = {OP_VSET, 2'b00,
                           desc[DESC_IN1_LSB +: 2],
                           desc[DESC_IN2_LSB +: 2],
                           7'b0,
                           desc[DESC_MUX_BIT],
                           desc[DESC_OUT_LSB +: 2]};
            4'd10: word = {OP_VSTART, 16'h0};
            4'd11: word = {OP_VDONE,  16'h0};
            default: word = 32'h0;
        endcase
    end

endmodule

// File: rtl/sfa_cmd_issuer.sv
// ---------------------------------------------------------------------------
// sfa_cmd_issuer
// Host-side initiator for the SFA command stream. Accepts one job descriptor,
// expands it into 12 instruction words (9 config, VSET, VSTART, VDONE),
// waits for the controller's return word and reports a status upstream.
// Optional feature macro: SFA_CMD_SKIP_UNCHANGED_EN -- skip config words
// whose operand matches the last value the controller accepted.
// Parameters:
//   RET_TIMEOUT  cycles to wait for the return word (0 = wait forever)
//   RET_EXPECT   return value reported as OK
// Ports:
//   ACLK, ARESET                      clock, synchronous active-high reset
//   sJOB_tvalid/tready/tdata[127:0]   job descriptor input
//   mCMD_tvalid/tready/tdata[31:0]    instruction word output
//   sRet_tvalid/tready/tdata[31:0]    return word input
//   mSTAT_tvalid/tready               status output handshake
//   mSTAT_code[1:0], mSTAT_ret[31:0]  status code and captured return word
// ---------------------------------------------------------------------------
module sfa_cmd_issuer
    import sfa_cmd_pkg::*;
#(
    parameter int unsigned RET_TIMEOUT = 1024,
    parameter logic [31:0] RET_EXPECT  = 32'd10
) (
    input  logic         ACLK,
    input  logic         ARESET,

    input  logic         sJOB_tvalid,
    output logic         sJOB_tready,
    input  logic [127:0] sJOB_tdata,

    output logic         mCMD_tvalid,
    input  logic         mCMD_tready,
    output logic [31:0]  mCMD_tdata,

    input  logic         sRet_tvalid,
    output logic         sRet_tready,
    input  logic [31:0]  sRet_tdata,

    output logic         mSTAT_tvalid,
    input  logic         mSTAT_tready,
    output logic [1:0]   mSTAT_code,
    output logic [31:0]  mSTAT_ret
);

    localparam bit          TIMEOUT_EN   = (RET_TIMEOUT != 0);
    localparam logic [31:0] TIMEOUT_LAST = 32'(RET_TIMEOUT - 1);

    issuer_state_t              state;
    logic [DESC_USED_WIDTH-1:0] desc_reg;
    logic [3:0]                 word_index;
    logic                       cmd_valid;
    logic [31:0]                cmd_data;
    logic [31:0]                ret_timer;
    logic [1:0]                 stat_code;
    logic [31:0]                stat_ret;

    logic [3:0]                 load_index;
    logic [DESC_USED_WIDTH-1:0] load_desc;
    logic [31:0]                load_word;
    logic                       load_skip;
    logic                       cmd_accept;
    logic                       timeout_hit;
    logic                       unused_desc_bits;

    assign unused_desc_bits = ^sJOB_tdata[127:DESC_USED_WIDTH];

    // The output register is always loaded with the *next* word to present:
    // word 0 from the incoming descriptor when a job is accepted, otherwise
    // the word after the current one from the stored descriptor.
    assign load_index = (state == IDLE) ? 4'd0 : 4'(word_index + 4'd1);
    assign load_desc  = (state == IDLE) ? sJOB_tdata[DESC_USED_WIDTH-1:0] : desc_reg;

    sfa_cmd_word_rom u_word_rom (
        .index (load_index),
        .desc  (load_desc),
        .word  (load_word)
    );

    assign cmd_accept  = cmd_valid && mCMD_tready;
    assign timeout_hit = TIMEOUT_EN && (state == WAIT_RET) && !sRet_tvalid
                         && (ret_timer == TIMEOUT_LAST);

`ifdef SFA_CMD_SKIP_UNCHANGED_EN
    logic [15:0]                 shadow_operand [NUM_CONFIG_WORDS];
    logic [NUM_CONFIG_WORDS-1:0] shadow_valid;

    // A config word is redundant when the controller already holds the same
    // operand from an earlier accepted word.
    always_comb begin
        load_skip = 1'b0;
        if (is_config_word(load_index)) begin
            load_skip = shadow_valid[load_index]
                        && (shadow_operand[load_index] == load_word[15:0]);
        end
    end

    // A timeout leaves the controller's state unknown, so forget everything.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            shadow_valid <= '0;
        end else if (timeout_hit) begin
            shadow_valid <= '0;
        end else if (cmd_accept && is_config_word(word_index)) begin
            shadow_valid[word_index]   <= 1'b1;
            shadow_operand[word_index] <= cmd_data[15:0];
        end
    end
`else
    assign load_skip = 1'b0;
`endif

    // Sequencer. In ISSUE the register pair (cmd_valid, cmd_data) holds the
    // word at word_index; it advances on a handshake, or unconditionally when
    // the current slot is a skipped word (cmd_valid low).
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state      <= IDLE;
            desc_reg   <= '0;
            word_index <= '0;
            cmd_valid  <= 1'b0;
            cmd_data   <= '0;
            ret_timer  <= '0;
            stat_code  <= STAT_OK;
            stat_ret   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sJOB_tvalid) begin
                        desc_reg   <= sJOB_tdata[DESC_USED_WIDTH-1:0];
                        word_index <= '0;
                        cmd_data   <= load_word;
                        cmd_valid  <= !load_skip;
                        state      <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (cmd_accept && (word_index == LAST_WORD_INDEX)) begin
                        cmd_valid <= 1'b0;
                        ret_timer <= '0;
                        state     <= WAIT_RET;
                    end else if (cmd_accept || !cmd_valid) begin
                        word_index <= load_index;
                        cmd_data   <= load_word;
                        cmd_valid  <= !load_skip;
                    end
                end

                WAIT_RET: begin
                    // A return word arriving on the expiry cycle still wins.
                    if (sRet_tvalid) begin
                        stat_ret  <= sRet_tdata;
                        stat_code <= (sRet_tdata == RET_EXPECT) ? STAT_OK : STAT_BAD_RET;
                        state     <= REPORT;
                    end else if (timeout_hit) begin
                        stat_ret  <= '0;
                        stat_code <= STAT_TIMEOUT;
                        state     <= REPORT;
                    end else begin
                        ret_timer <= ret_timer + 32'd1;
                    end
                end

                REPORT: begin
                    if (mSTAT_tready) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign sJOB_tready  = (state == IDLE);
    assign sRet_tready  = (state == WAIT_RET);
    assign mSTAT_tvalid = (state == REPORT);
    assign mCMD_tvalid  = cmd_valid;
    assign mCMD_tdata   = cmd_data;
    assign mSTAT_code   = stat_code;
    assign mSTAT_ret    = stat_ret;

endmodule

// File: tb/tb_sfa_cmd_issuer.sv
// ---------------------------------------------------------------------------
// tb_sfa_cmd_issuer
// Directed bench for sfa_cmd_issuer. Expected instruction words and status
// words are queued when stimulus is issued; monitor processes pop and compare
// them whenever the DUT completes a handshake.
// ---------------------------------------------------------------------------
module tb_sfa_cmd_issuer;

    localparam int unsigned TB_RET_TIMEOUT = 16;

    logic         ACLK = 1'b0;
    logic         ARESET;
    logic         sJOB_tvalid;
    logic         sJOB_tready;
    logic [127:0] sJOB_tdata;
    logic         mCMD_tvalid;
    logic         mCMD_tready;
    logic [31:0]  mCMD_tdata;
    logic         sRet_tvalid;
    logic         sRet_tready;
    logic [31:0]  sRet_tdata;
    logic         mSTAT_tvalid;
    logic         mSTAT_tready;
    logic [1:0]   mSTAT_code;
    logic [31:0]  mSTAT_ret;

    int checks = 0;
    int errors = 0;

    logic [31:0] cmd_exp [$];
    logic [33:0] stat_exp [$];

    logic [31:0]  words_a [12];
    logic [31:0]  words_b [12];
    logic [31:0]  words_c [12];
    logic [127:0] desc_a, desc_b, desc_c;

    logic        hold_pending = 1'b0;
    logic [31:0] hold_data    = 32'h0;

`ifdef SFA_CMD_SKIP_UNCHANGED_EN
    logic [15:0] m_shadow [9];
    logic        m_valid  [9];
`endif

    sfa_cmd_issuer #(
        .RET_TIMEOUT (TB_RET_TIMEOUT),
        .RET_EXPECT  (32'd10)
    ) dut (
        .ACLK         (ACLK),
        .ARESET       (ARESET),
        .sJOB_tvalid  (sJOB_tvalid),
        .sJOB_tready  (sJOB_tready),
        .sJOB_tdata   (sJOB_tdata),
        .mCMD_tvalid  (mCMD_tvalid),
        .mCMD_tready  (mCMD_tready),
        .mCMD_tdata   (mCMD_tdata),
        .sRet_tvalid  (sRet_tvalid),
        .sRet_tready  (sRet_tready),
        .sRet_tdata   (sRet_tdata),
        .mSTAT_tvalid (mSTAT_tvalid),
        .mSTAT_tready (mSTAT_tready),
        .mSTAT_code   (mSTAT_code),
        .mSTAT_ret    (mSTAT_ret)
    );

    always #5 ACLK = ~ACLK;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [127:0] makeDesc(
        input logic [15:0] pr, input logic [15:0] b1i, input logic [15:0] b1s,
        input logic [15:0] b1t, input logic b1m,
        input logic [15:0] b2i, input logic [15:0] b2s, input logic [15:0] b2t,
        input logic b2m, input logic [1:0] in1, input logic [1:0] in2,
        input logic mux, input logic [1:0] out_sel);
        logic [127:0] d;
        d = '0;
        d[15:0]    = pr;
        d[31:16]   = b1i;
        d[47:32]   = b1s;
        d[63:48]   = b1t;
        d[79:64]   = b2i;
        d[95:80]   = b2s;
        d[111:96]  = b2t;
        d[112]     = b1m;
        d[113]     = b2m;
        d[115:114] = in1;
        d[117:116] = in2;
        d[118]     = mux;
        d[120:119] = out_sel;
        d[127:121] = 7'h5A;
        return d;
    endfunction

    // Queue the words the controller should see for one job.
    task automatic pushWords(input logic [31:0] words [12], output int n);
        n = 0;
        for (int i = 0; i < 12; i++) begin
`ifdef SFA_CMD_SKIP_UNCHANGED_EN
            if (i < 9 && m_valid[i] && m_shadow[i] == words[i][15:0]) continue;
            if (i < 9) begin
                m_valid[i]  = 1'b1;
                m_shadow[i] = words[i][15:0];
            end
`endif
            cmd_exp.push_back(words[i]);
            n++;
        end
    endtask

    task automatic modelInvalidate();
`ifdef SFA_CMD_SKIP_UNCHANGED_EN
        for (int i = 0; i < 9; i++) m_valid[i] = 1'b0;
`endif
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Drive mCMD_tready until n words have been handed over.
    task automatic issueWords(input int n, input bit random_ready, input bit check_burst);
        int accepted = 0;
        int cycles   = 0;
        int first    = -1;
        while (accepted < n && cycles < 400) begin
            mCMD_tready = random_ready ? ($urandom_range(0, 1) != 0) : 1'b1;
            @(negedge ACLK);
            if (mCMD_tvalid && first < 0) first = cycles;
            if (mCMD_tvalid && mCMD_tready) accepted++;
            tick();
            cycles++;
        end
        mCMD_tready = 1'b0;
        checkOutput("issue_count", accepted, n);
        if (check_burst) checkOutput("issue_burst_cycles", cycles - first, n);
    endtask

    task automatic applyStimulus(input logic [127:0] desc, input int n,
                                 input bit random_ready, input bit check_first,
                                 input bit check_burst, input bit complete);
        int k = 0;
        while (!sJOB_tready && k < 50) begin
            tick();
            k++;
        end
        checkOutput("job_ready", sJOB_tready, 1);
        sJOB_tvalid = 1'b1;
        sJOB_tdata  = desc;
        tick();
        sJOB_tvalid = 1'b0;
        sJOB_tdata  = {4{32'hDEAD_BEEF}};
        checkOutput("job_ready_low", sJOB_tready, 0);
        if (check_first) checkOutput("first_cmd_latency", mCMD_tvalid, 1);
        issueWords(n, random_ready, check_burst);
        if (complete) begin
            checkOutput("ret_ready_latency", sRet_tready, 1);
            checkOutput("cmd_valid_after_last", mCMD_tvalid, 0);
        end
    endtask

    task automatic sendReturn(input logic [31:0] ret, input logic [1:0] code);
        stat_exp.push_back({code, ret});
        sRet_tvalid = 1'b1;
        sRet_tdata  = ret;
        tick();
        sRet_tvalid = 1'b0;
        sRet_tdata  = 32'h0;
        checkOutput("stat_latency", mSTAT_tvalid, 1);
        checkOutput("ret_ready_low", sRet_tready, 0);
    endtask

    // Hold mSTAT_tready low for a while, then accept the status.
    task automatic acceptStatus(input int hold);
        logic [33:0] exp;
        exp = (stat_exp.size() != 0) ? stat_exp[0] : 34'h0;
        for (int i = 0; i < hold; i++) begin
            checkOutput("stat_hold_valid", mSTAT_tvalid, 1);
            checkOutput("stat_hold_fields", {mSTAT_code, mSTAT_ret}, exp);
            checkOutput("stat_hold_job_ready", sJOB_tready, 0);
            tick();
        end
        mSTAT_tready = 1'b1;
        tick();
        mSTAT_tready = 1'b0;
        checkOutput("idle_after_report", sJOB_tready, 1);
        checkOutput("stat_valid_cleared", mSTAT_tvalid, 0);
        checkOutput("stat_fields_retained", {mSTAT_code, mSTAT_ret}, exp);
    endtask

    task automatic checkQueues(input string tag);
        checkOutput({tag, "_cmd_queue_empty"}, cmd_exp.size(), 0);
        checkOutput({tag, "_stat_queue_empty"}, stat_exp.size(), 0);
    endtask

    // Command scoreboard and hold-stability monitor.
    always @(negedge ACLK) begin
        if (ARESET) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                checkOutput("cmd_hold_valid", mCMD_tvalid, 1);
                checkOutput("cmd_hold_data", mCMD_tdata, hold_data);
            end
            if (mCMD_tvalid && mCMD_tready) begin
                if (cmd_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL cmd_unexpected: got 0x%0h, expected no word", mCMD_tdata);
                end else begin
                    checkOutput("cmd_word", mCMD_tdata, cmd_exp.pop_front());
                end
            end
            hold_pending = mCMD_tvalid && !mCMD_tready;
            hold_data    = mCMD_tdata;
        end
    end

    // Status scoreboard.
    always @(negedge ACLK) begin
        if (!ARESET && mSTAT_tvalid && mSTAT_tready) begin
            if (stat_exp.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL stat_unexpected: got 0x%0h, expected no status",
                         {mSTAT_code, mSTAT_ret});
            end else begin
                checkOutput("stat_word", {mSTAT_code, mSTAT_ret}, stat_exp.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int k;

        ARESET       = 1'b1;
        sJOB_tvalid  = 1'b0;
        sJOB_tdata   = '0;
        mCMD_tready  = 1'b0;
        sRet_tvalid  = 1'b0;
        sRet_tdata   = '0;
        mSTAT_tready = 1'b0;
        modelInvalidate();

        desc_a = makeDesc(16'h0040, 16'h0000, 16'h0040, 16'h0001, 1'b1,
                          16'h0100, 16'h0040, 16'h0001, 1'b0, 2'd1, 2'd2, 1'b1, 2'd3);
        desc_b = makeDesc(16'h0040, 16'h0000, 16'h0040, 16'h0001, 1'b1,
                          16'h0100, 16'h0080, 16'h0001, 1'b0, 2'd1, 2'd2, 1'b1, 2'd3);
        desc_c = makeDesc(16'h1234, 16'hABCD, 16'h0F0F, 16'h0002, 1'b0,
                          16'h5555, 16'hAAAA, 16'hFFFF, 1'b1, 2'd3, 2'd0, 1'b0, 2'd1);
        words_a = '{32'h00100040, 32'h00110000, 32'h00120040, 32'h00130001,
                    32'h00140001, 32'h00210100, 32'h00220040, 32'h00230001,
                    32'h00240000, 32'h00011807, 32'h00030000, 32'h00080000};
        words_b = '{32'h00100040, 32'h00110000, 32'h00120040, 32'h00130001,
                    32'h00140001, 32'h00210100, 32'h00220080, 32'h00230001,
                    32'h00240000, 32'h00011807, 32'h00030000, 32'h00080000};
        words_c = '{32'h00101234, 32'h0011ABCD, 32'h00120F0F, 32'h00130002,
                    32'h00140000, 32'h00215555, 32'h0022AAAA, 32'h0023FFFF,
                    32'h00240001, 32'h00013001, 32'h00030000, 32'h00080000};

        repeat (3) @(posedge ACLK);
        #1;
        checkOutput("reset_job_ready", sJOB_tready, 1);
        checkOutput("reset_cmd_valid", mCMD_tvalid, 0);
        checkOutput("reset_cmd_data", mCMD_tdata, 0);
        checkOutput("reset_ret_ready", sRet_tready, 0);
        checkOutput("reset_stat_valid", mSTAT_tvalid, 0);
        checkOutput("reset_stat_code", mSTAT_code, 0);
        checkOutput("reset_stat_ret", mSTAT_ret, 0);
        ARESET = 1'b0;
        tick();

        $display("[TB] job A, full throughput, good return");
        pushWords(words_a, n);
        applyStimulus(desc_a, n, 1'b0, 1'b1, 1'b1, 1'b1);
        sendReturn(32'h0000000A, 2'b00);
        acceptStatus(0);
        checkQueues("jobA");

        $display("[TB] job C, random backpressure, bad return");
        pushWords(words_c, n);
        applyStimulus(desc_c, n, 1'b1, 1'b1, 1'b0, 1'b1);
        sendReturn(32'h0000000B, 2'b01);
        acceptStatus(2);
        checkQueues("jobC");

        $display("[TB] job A, no return, timeout");
        pushWords(words_a, n);
        applyStimulus(desc_a, n, 1'b0, 1'b1, 1'b0, 1'b1);
        stat_exp.push_back({2'b10, 32'h0});
        k = 0;
        while (k < 100) begin
            tick();
            k++;
            if (mSTAT_tvalid) break;
        end
        checkOutput("timeout_cycles", k, TB_RET_TIMEOUT);
        acceptStatus(0);
        modelInvalidate();
        checkQueues("timeout");

        $display("[TB] job A, reset after word 5");
        pushWords(words_a, n);
        applyStimulus(desc_a, 6, 1'b0, 1'b1, 1'b0, 1'b0);
        ARESET = 1'b1;
        tick();
        checkOutput("abort_job_ready", sJOB_tready, 1);
        checkOutput("abort_cmd_valid", mCMD_tvalid, 0);
        checkOutput("abort_cmd_data", mCMD_tdata, 0);
        checkOutput("abort_stat_code", mSTAT_code, 0);
        checkOutput("abort_ret_ready", sRet_tready, 0);
        ARESET = 1'b0;
        cmd_exp.delete();
        modelInvalidate();
        tick();

        $display("[TB] job A restart, status held for 20 cycles");
        pushWords(words_a, n);
        applyStimulus(desc_a, n, 1'b0, 1'b1, 1'b1, 1'b1);
        sendReturn(32'h0000000A, 2'b00);
        acceptStatus(20);
        checkQueues("restart");

        $display("[TB] job A repeated");
        pushWords(words_a, n);
        applyStimulus(desc_a, n, 1'b0, (n == 12), 1'b0, 1'b1);
        sendReturn(32'h0000000A, 2'b00);
        acceptStatus(0);
        checkQueues("repeat");

        $display("[TB] job B, BC2_SIZE changed");
        pushWords(words_b, n);
        applyStimulus(desc_b, n, 1'b0, (n == 12), 1'b0, 1'b1);
        sendReturn(32'h0000000A, 2'b00);
        acceptStatus(1);
        checkQueues("jobB");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
